// File: rtl/nios_system_color_pkg.sv
// Shared constants and types for the inbound colour mailbox.
package nios_system_color_pkg;

  localparam int DEFAULT_DATA_W = 16;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_STATUS   = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;

  localparam int STAT_FULL    = 0;
  localparam int STAT_OVERRUN = 1;

  typedef enum logic {
    MB_EMPTY = 1'b0,
    MB_FULL  = 1'b1
  } mb_state_e;

endpackage

// File: rtl/nios_system_color_to.sv
// Avalon-MM slave holding one colour sample from fabric until the CPU reads it.
//
// state    | meaning
// MB_EMPTY | no sample held, in_ready=1, in_valid latches in_data
// MB_FULL  | sample held, in_ready=0, in_valid is a drop, DATA read pops
module nios_system_color_to
  import nios_system_color_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              irq
);

  mb_state_e         state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              overrun_q, overrun_d;
  logic [1:0]        irq_mask_q, irq_mask_d;

  logic full;
  logic pop;
  logic wr_en;
  logic unused_wd;

  assign full      = (state_q == MB_FULL);
  assign pop       = chipselect & ~read_n & (address == ADDR_DATA);
  assign wr_en     = chipselect & ~write_n;
  assign unused_wd = ^writedata[31:2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= MB_EMPTY;
      data_q     <= '0;
      overrun_q  <= 1'b0;
      irq_mask_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      overrun_q  <= overrun_d;
      irq_mask_q <= irq_mask_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    overrun_d  = overrun_q;
    irq_mask_d = irq_mask_q;

    if (wr_en && address == ADDR_STATUS && writedata[STAT_OVERRUN])
      overrun_d = 1'b0;
    if (wr_en && address == ADDR_IRQ_MASK)
      irq_mask_d = writedata[1:0];

    // The drop is evaluated after the clear so a same-cycle drop keeps OVERRUN set.
    case (state_q)
      MB_EMPTY: begin
        if (in_valid) begin
          data_d  = in_data;
          state_d = MB_FULL;
        end
      end
      MB_FULL: begin
        if (in_valid)
          overrun_d = 1'b1;
        if (pop)
          state_d = MB_EMPTY;
      end
      default: state_d = MB_EMPTY;
    endcase
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata[DATA_W-1:0] = data_q;
      ADDR_STATUS: begin
        readdata[STAT_FULL]    = full;
        readdata[STAT_OVERRUN] = overrun_q;
      end
      ADDR_IRQ_MASK: readdata[1:0] = irq_mask_q;
      default:       readdata = '0;
    endcase
  end

  assign in_ready = ~full;
  assign irq      = |(irq_mask_q & {overrun_q, full});

endmodule

// File: tb/tb_nios_system_color_to.sv
// Directed testbench for the inbound colour mailbox.
module tb_nios_system_color_to;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        irq;

  int checks;
  int errors;

  nios_system_color_to #(.DATA_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus read: value captured combinationally before the edge that may pop.
  task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1;
    read_n     = 1'b0;
    address    = a;
    #1;
    d = readdata;
    tick();
    chipselect = 1'b0;
    read_n     = 1'b1;
    address    = 2'd3;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic offer(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset_n = 1'b0;
    #3;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: got %b expected 0", irq);
    end
    for (int a = 0; a < 4; a++) begin
      cpu_read(a[1:0], rd);
      checks++;
      if (rd !== 32'h0) begin
        errors++;
        $display("FAIL reset_read_addr%0d: got %h expected 00000000", a, rd);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_accept_pop();
    logic [31:0] rd;
    offer(16'hF81F);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL accept_in_ready: got %b expected 0", in_ready);
    end
    cpu_read(2'd1, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL accept_status: got %h expected 00000001", rd);
    end
    cpu_read(2'd0, rd);
    checks++;
    if (rd !== 32'h0000F81F) begin
      errors++;
      $display("FAIL pop_data: got %h expected 0000f81f", rd);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL pop_in_ready: got %b expected 1", in_ready);
    end
    cpu_read(2'd1, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL pop_status: got %h expected 00000000", rd);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] rd;
    offer(16'h07E0);
    offer(16'h001F);
    cpu_read(2'd1, rd);
    checks++;
    if (rd !== 32'h3) begin
      errors++;
      $display("FAIL overrun_status: got %h expected 00000003", rd);
    end
    cpu_write(2'd1, 32'h2);
    cpu_read(2'd1, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL overrun_w1c: got %h expected 00000001", rd);
    end
    cpu_read(2'd0, rd);
    checks++;
    if (rd !== 32'h000007E0) begin
      errors++;
      $display("FAIL overrun_data_kept: got %h expected 000007e0", rd);
    end
    // Pop while empty returns stale data and changes nothing.
    cpu_read(2'd0, rd);
    checks++;
    if (rd !== 32'h000007E0) begin
      errors++;
      $display("FAIL empty_pop_stale: got %h expected 000007e0", rd);
    end
  endtask

  task automatic test_irq_mask();
    logic [31:0] rd;
    offer(16'h1111);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_masked: got %b expected 0", irq);
    end
    cpu_write(2'd2, 32'hFFFF_FFFD);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_full_enabled: got %b expected 1", irq);
    end
    cpu_read(2'd2, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL irq_mask_readback: got %h expected 00000001", rd);
    end
    cpu_read(2'd0, rd);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_after_pop: got %b expected 0", irq);
    end
    cpu_write(2'd2, 32'h2);
    offer(16'h2222);
    offer(16'h3333);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_overrun: got %b expected 1", irq);
    end
    cpu_write(2'd1, 32'h2);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_overrun_cleared: got %b expected 0", irq);
    end
    cpu_read(2'd0, rd);
    checks++;
    if (rd !== 32'h00002222) begin
      errors++;
      $display("FAIL irq_overrun_data: got %h expected 00002222", rd);
    end
    cpu_write(2'd2, 32'h0);
  endtask

  task automatic test_simultaneous();
    logic [31:0] rd;
    offer(16'h1234);
    chipselect = 1'b1;
    read_n     = 1'b0;
    address    = 2'd0;
    in_valid   = 1'b1;
    in_data    = 16'hFFFF;
    #1;
    rd = readdata;
    tick();
    chipselect = 1'b0;
    read_n     = 1'b1;
    in_valid   = 1'b0;
    checks++;
    if (rd !== 32'h00001234) begin
      errors++;
      $display("FAIL simul_pop_data: got %h expected 00001234", rd);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL simul_in_ready: got %b expected 1", in_ready);
    end
    cpu_read(2'd1, rd);
    checks++;
    if (rd !== 32'h2) begin
      errors++;
      $display("FAIL simul_status: got %h expected 00000002", rd);
    end
    cpu_read(2'd0, rd);
    checks++;
    if (rd !== 32'h00001234) begin
      errors++;
      $display("FAIL simul_data_kept: got %h expected 00001234", rd);
    end
    cpu_write(2'd1, 32'h2);
    // Clear and new drop in the same cycle: the drop wins.
    offer(16'h5555);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 2'd1;
    writedata  = 32'h2;
    in_valid   = 1'b1;
    in_data    = 16'h6666;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_valid   = 1'b0;
    cpu_read(2'd1, rd);
    checks++;
    if (rd !== 32'h3) begin
      errors++;
      $display("FAIL clear_vs_drop: got %h expected 00000003", rd);
    end
    cpu_read(2'd0, rd);
    checks++;
    if (rd !== 32'h00005555) begin
      errors++;
      $display("FAIL clear_vs_drop_data: got %h expected 00005555", rd);
    end
    cpu_write(2'd1, 32'h2);
  endtask

  task automatic test_async_reset();
    logic [31:0] rd;
    cpu_write(2'd2, 32'h3);
    offer(16'hABCD);
    offer(16'h0001);
    checks++;
    if (irq !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_state: got irq=%b in_ready=%b expected irq=1 in_ready=0", irq, in_ready);
    end
    #2;
    reset_n = 1'b0;
    address = 2'd1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL async_irq: got %b expected 0", irq);
    end
    checks++;
    if (readdata !== 32'h0) begin
      errors++;
      $display("FAIL async_status: got %h expected 00000000", readdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    cpu_read(2'd0, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL async_data_discarded: got %h expected 00000000", rd);
    end
    cpu_read(2'd2, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL async_mask_cleared: got %h expected 00000000", rd);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset_n    = 1'b0;
    address    = 2'd3;
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    writedata  = '0;
    in_data    = '0;
    in_valid   = 1'b0;

    test_reset();
    test_accept_pop();
    test_overrun();
    test_irq_mask();
    test_simultaneous();
    test_async_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
